// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package instr_fetch_pkg;
  typedef logic [7:0] addr_t;
  typedef logic [7:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam addr_t  DEF_RESET_PC    = 8'h00;
  localparam instr_t DEF_HALT_OPCODE = 8'hFF;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: load-target beats increment; otherwise holds. Wraps mod 256.
module fetch_pc_reg import instr_fetch_pkg::*; #(
  parameter addr_t RESET_PC = DEF_RESET_PC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load_tgt_i,
  input  addr_t tgt_i,
  input  logic  inc_i,
  output addr_t pc_o
);
  addr_t pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_tgt_i)  pc_d = tgt_i;
    else if (inc_i)  pc_d = pc_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: drives imem address, captures one instruction into an
// output register for decode, and handles branch flush, HALT and restart.
module instr_fetch_ctrl import instr_fetch_pkg::*; #(
  parameter addr_t  RESET_PC    = DEF_RESET_PC,
  parameter instr_t HALT_OPCODE = DEF_HALT_OPCODE,
  parameter int     CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output addr_t            imem_addr,
  input  instr_t           imem_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output instr_t           instr_out,
  output addr_t            instr_pc,
  input  logic             branch_taken,
  input  addr_t            branch_target,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);
  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  instr_t           out_q, out_d;
  addr_t            ipc_q, ipc_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  addr_t pc;
  logic  pc_ld, pc_inc;
  addr_t pc_tgt;
  logic  active, flush, accept, load;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_tgt_i (pc_ld),
    .tgt_i      (pc_tgt),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  // Branch only redirects while fetching; in HALTED it is ignored and the
  // pending HALT instruction may still be accepted.
  assign active = (state_q == ST_FETCH) || (state_q == ST_HOLD);
  assign flush  = active && branch_taken;
  assign accept = valid_q && instr_ready && !flush;
  assign load   = active && !branch_taken && (!valid_q || instr_ready);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    out_d    = out_q;
    ipc_d    = ipc_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    pc_ld    = 1'b0;
    pc_tgt   = branch_target;
    pc_inc   = 1'b0;

    if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    if (accept) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH, ST_HOLD: begin
        if (flush) begin
          pc_ld   = 1'b1;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end else if (load) begin
          out_d   = imem_data;
          ipc_d   = pc;
          valid_d = 1'b1;
          pc_inc  = 1'b1;
          if (imem_data == HALT_OPCODE) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_FETCH;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        if (start && !valid_q) begin
          pc_ld    = 1'b1;
          pc_tgt   = RESET_PC;
          halted_d = 1'b0;
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      out_q    <= '0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr   = pc;
  assign instr_valid = valid_q;
  assign instr_out   = out_q;
  assign instr_pc    = ipc_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;
endmodule
